pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//   Program-counter and instruction-fetch stage of the MIPS core. Consumes the
//   shifted branch offset (sl2, 32b) and shifted jump index (sl2 of {2'b00,idx}, 28b),
//   forms the next PC and fetches from instruction memory over a req/ack handshake.
//   Holds each fetched instruction until the datapath accepts it with en.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC loaded on reset; first fetch address
//   MAX_WAIT   15             max cycles imem_req may wait for imem_ack before timeout
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   en           in   1   datapath accepts current instruction (PCWrite)
//   br_taken     in   1   conditional branch taken (valid with en)
//   br_off_sl2   in   32  sign-extended imm << 2, from sl2 #(32)
//   jump         in   1   j/jal (valid with en)
//   jidx_sl2     in   28  instr_index << 2, from sl2
//   jr           in   1   jr/jalr (valid with en)
//   jr_addr      in   32  register target for jr
//   imem_req     out  1   fetch request, held high until ack
//   imem_addr    out  32  fetch address, stable while imem_req=1
//   imem_ack     in   1   one-cycle pulse: imem_rdata valid this cycle
//   imem_rdata   in   32  fetched word
//   pc           out  32  address of instr
//   pc_plus4     out  32  pc + 4 (for jal link)
//   instr        out  32  held instruction
//   instr_valid  out  1   instr/pc valid for datapath
//   misalign     out  1   sticky: a redirect target had [1:0] != 0
//   fetch_err    out  1   sticky: imem_ack not received within MAX_WAIT cycles
// BEHAVIOUR
//   Reset (async, any state): pc=RESET_PC, imem_req=0, instr=0, instr_valid=0,
//     misalign=0, fetch_err=0, wait counter=0, state=FETCH.
//   States: FETCH -> WAIT -> HOLD -> FETCH; ERR terminal until reset.
//   FETCH: drive imem_req=1, imem_addr=pc; go WAIT next cycle (req stays 1).
//   WAIT: imem_req=1. On imem_ack: instr<=imem_rdata, instr_valid<=1, req drops next
//     cycle, go HOLD. Counter increments each WAIT cycle without ack; reaching MAX_WAIT
//     sets fetch_err, drops req, go ERR (instr_valid stays 0).
//   HOLD: instr_valid=1. en=0 -> stay, all outputs stable. en=1 -> pc<=next_pc,
//     instr_valid<=0, go FETCH. Fetch latency reset->first instr_valid: 2 cycles + imem wait.
//   en while instr_valid=0 is ignored; redirect inputs sampled only on HOLD & en.
//   next_pc priority: jr > jump > br_taken > sequential:
//     jr: jr_addr; jump: {pc_plus4[31:28], jidx_sl2};
//     branch: pc_plus4 + br_off_sl2 (mod 2^32, wraps silently); else pc_plus4.
//   pc_plus4 = pc + 4 combinational, wraps 32'hFFFF_FFFC -> 0.
//   Misaligned target ([1:0]!=0): misalign<=1 (sticky), next_pc[1:0] forced to 2'b00.
//   imem_ack outside WAIT is ignored. Reset mid-WAIT aborts fetch; late ack ignored.
// TESTING
//   1 reset, ack after 1 cycle with 32'h2008_0005 -> imem_addr=0x3000, instr_valid=1,
//     pc=0x3000; en=1 -> next imem_addr=0x3004.
//   2 pc=0x3008, br_taken=1, br_off_sl2=32'hFFFF_FFF8, en=1 -> next pc=0x3004.
//   3 pc=0x3000, jump=1, jidx_sl2=28'h000_3010, br_taken=1 also -> pc=0x0000_3010.
//   4 jr=1, jr_addr=0x0000_3022, jump=1 -> pc=0x0000_3020, misalign=1 and stays 1.
//   5 HOLD with en=0 for 5 cycles, spurious imem_ack -> instr/pc unchanged, no req.
//   6 ack withheld MAX_WAIT cycles -> fetch_err=1, imem_req=0; reset clears, refetch 0x3000.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage.
// Forms the next PC from branch/jump/jr redirects, fetches over a req/ack
// handshake and holds each fetched word until the datapath accepts it with en.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        br_taken,
  input  logic [31:0] br_off_sl2,
  input  logic        jump,
  input  logic [27:0] jidx_sl2,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StErr} state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [31:0]     target;
  logic [31:0]     next_pc;
  logic            target_mis;

  assign pc_plus4  = pc + 32'd4;
  // pc only changes on leaving HOLD, so the address is stable for the whole request
  assign imem_addr = pc;

  // Redirect target selection: jr > jump > branch > sequential; low bits forced aligned
  always_comb begin
    target = pc_plus4;
    if (jr) begin
      target = jr_addr;
    end else if (jump) begin
      target = {pc_plus4[31:28], jidx_sl2};
    end else if (br_taken) begin
      target = pc_plus4 + br_off_sl2;
    end
    target_mis = (target[1:0] != 2'b00);
    next_pc    = {target[31:2], 2'b00};
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      wait_cnt_q  <= '0;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          imem_req   <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= StHold;
          end else if (wait_cnt_q == CntW'(MAX_WAIT - 1)) begin
            // This was the last permitted wait cycle; give up until reset
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state_q   <= StErr;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StHold: begin
          if (en) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            if (target_mis) begin
              misalign <= 1'b1;
            end
            state_q <= StFetch;
          end
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          state_q <= StErr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized
// redirects and memory latencies compared against a behavioural PC model.
module tb_pc_fetch;

  localparam int unsigned MaxWait = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        br_taken;
  logic [31:0] br_off_sl2;
  logic        jump;
  logic [27:0] jidx_sl2;
  logic        jr;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;

  pc_fetch #(
    .RESET_PC(32'h0000_3000),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .br_taken   (br_taken),
    .br_off_sl2 (br_off_sl2),
    .jump       (jump),
    .jidx_sl2   (jidx_sl2),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .misalign   (misalign),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en         = 1'b0;
    br_taken   = 1'b0;
    br_off_sl2 = 32'h0;
    jump       = 1'b0;
    jidx_sl2   = 28'h0;
    jr         = 1'b0;
    jr_addr    = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    check_eq("rst_pc", pc, 32'h0000_3000);
    check_eq("rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_mis", {31'h0, misalign}, 32'h0);
    check_eq("rst_err", {31'h0, fetch_err}, 32'h0);
    tick();
    tick();
    reset   = 1'b0;
    m_pc    = 32'h0000_3000;
    m_mis   = 1'b0;
    m_instr = 32'h0;
  endtask

  // Wait for a request, hold ack off for 'delay' cycles, then return 'data'.
  // With noise set, en/jr are toggled while no instruction is valid; they must be ignored.
  task automatic do_fetch(input int delay, input logic [31:0] data, input bit noise);
    int n = 0;
    while (!imem_req && n < 4) begin
      tick();
      n++;
    end
    check_eq("req_rise", {31'h0, imem_req}, 32'h1);
    check_eq("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < delay; i++) begin
      if (noise) begin
        en      = 1'($urandom_range(0, 1));
        jr      = 1'b1;
        jr_addr = $urandom;
      end
      tick();
    end
    en       = 1'b0;
    jr       = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    m_instr  = data;
    check_eq("valid_set", {31'h0, instr_valid}, 32'h1);
    check_eq("instr", instr, m_instr);
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("req_drop", {31'h0, imem_req}, 32'h0);
  endtask

  // Present a redirect with en in HOLD and update the model from the PC rules
  task automatic redirect(input logic r_jr, input logic [31:0] r_jaddr, input logic r_jump,
                          input logic [27:0] r_jidx, input logic r_br, input logic [31:0] r_off);
    logic [31:0] seq;
    logic [31:0] tgt;
    jr = r_jr; jr_addr = r_jaddr; jump = r_jump; jidx_sl2 = r_jidx;
    br_taken = r_br; br_off_sl2 = r_off; en = 1'b1;
    tick();
    clear_inputs();
    seq = m_pc + 32'd4;
    if (r_jr)        tgt = r_jaddr;
    else if (r_jump) tgt = {seq[31:28], r_jidx};
    else if (r_br)   tgt = seq + r_off;
    else             tgt = seq;
    if (tgt % 4 != 0) m_mis = 1'b1;
    m_pc = tgt - (tgt % 4);
    check_eq("redir_pc", pc, m_pc);
    check_eq("redir_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("misalign", {31'h0, misalign}, {31'h0, m_mis});
  endtask

  task automatic hold_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick();
      check_eq("hold_instr", instr, m_instr);
      check_eq("hold_pc", pc, m_pc);
      check_eq("hold_req", {31'h0, imem_req}, 32'h0);
      check_eq("hold_valid", {31'h0, instr_valid}, 32'h1);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] off;
    logic [31:0] ja;
    logic [27:0] ji;
    do_reset();

    // Reset fetch and sequential step
    do_fetch(0, 32'h2008_0005, 1'b0);
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b0, 32'h0);
    check_eq("t1_pc", pc, 32'h0000_3004);
    do_fetch(1, 32'h1111_1111, 1'b1);
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b0, 32'h0);
    do_fetch(2, 32'h2222_2222, 1'b0);
    // Backward branch
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b1, 32'hFFFF_FFF8);
    check_eq("t2_pc", pc, 32'h0000_3004);
    do_fetch(0, 32'h3333_3333, 1'b0);
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b1, 32'hFFFF_FFF8);
    check_eq("t3_pre_pc", pc, 32'h0000_3000);
    do_fetch(0, 32'h4444_4444, 1'b0);
    // Jump beats branch
    redirect(1'b0, 32'h0, 1'b1, 28'h000_3010, 1'b1, 32'h0000_0100);
    check_eq("t3_pc", pc, 32'h0000_3010);
    do_fetch(3, 32'h5555_5555, 1'b1);
    // jr beats jump, misaligned target
    redirect(1'b1, 32'h0000_3022, 1'b1, 28'h000_0040, 1'b0, 32'h0);
    check_eq("t4_pc", pc, 32'h0000_3020);
    check_eq("t4_mis", {31'h0, misalign}, 32'h1);
    do_fetch(MaxWait - 1, 32'h6666_6666, 1'b0);
    hold_idle(5);
    check_eq("t4_mis_sticky", {31'h0, misalign}, 32'h1);
    // pc_plus4 wrap at top of address space
    redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 28'h0, 1'b0, 32'h0);
    do_fetch(0, 32'h7777_7777, 1'b0);
    check_eq("wrap_p4", pc_plus4, 32'h0);
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b0, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    do_fetch(0, 32'h8888_8888, 1'b0);

    // Randomized redirects, latencies and hold times
    for (int it = 0; it < 40; it++) begin
      off = 32'($signed($urandom_range(0, 65535) - 32768)) <<< 2;
      ja  = $urandom;
      if ($urandom_range(0, 7) != 0) ja[1:0] = 2'b00;
      ji  = 28'($urandom);
      if ($urandom_range(0, 7) != 0) ji[1:0] = 2'b00;
      redirect($urandom_range(0, 3) == 0, ja, $urandom_range(0, 3) == 0, ji,
               $urandom_range(0, 1) == 1, off);
      do_fetch(int'($urandom_range(0, MaxWait - 1)), $urandom, 1'b1);
      hold_idle(int'($urandom_range(0, 3)));
    end

    // Fetch timeout
    redirect(1'b0, 32'h0, 1'b0, 28'h0, 1'b0, 32'h0);
    tick();
    check_eq("to_req", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < int'(MaxWait) - 1; i++) tick();
    check_eq("to_err_early", {31'h0, fetch_err}, 32'h0);
    check_eq("to_req_early", {31'h0, imem_req}, 32'h1);
    tick();
    check_eq("to_err", {31'h0, fetch_err}, 32'h1);
    check_eq("to_req_drop", {31'h0, imem_req}, 32'h0);
    check_eq("to_valid", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_eq("err_stuck", {31'h0, fetch_err}, 32'h1);
    check_eq("err_valid", {31'h0, instr_valid}, 32'h0);
    do_reset();
    do_fetch(0, 32'h2008_0005, 1'b0);

    // Reset in the middle of a wait; a late ack must not complete the aborted fetch
    do_reset();
    tick();
    tick();
    check_eq("mid_req", {31'h0, imem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_req_abort", {31'h0, imem_req}, 32'h0);
    tick();
    reset    = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    check_eq("late_ack_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("late_ack_instr", instr, 32'h0);
    do_fetch(1, 32'h0BAD_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
